// File: rtl/lpf_ctrl_pkg.sv
// Shared types, defaults and helpers for filter control sequencing.
// Used by the parameter sequencer and related schedulers.
package lpf_ctrl_pkg;

    localparam int COEF_W = 16;

    typedef logic signed [COEF_W-1:0] coef_t;

    localparam coef_t STEP_DEF    = 16'sd256;
    localparam coef_t G_MAX_DEF   = 16'sd32767;
    localparam coef_t RES_MAX_DEF = 16'sd32767;
    localparam coef_t G_INIT_DEF  = 16'sd4096;

    // Pin a value into the stable range [0, hi].
    function automatic int clamp_range(input int v, input int hi);
        if (v < 0)
            return 0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    // Limit a difference to [-step, +step].
    function automatic int step_limit(input int d, input int step);
        if (d > step)
            return step;
        else if (d < -step)
            return -step;
        else
            return d;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered pointer.
// Pointer moves past the granted requester on each grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;

    // Pick first requester at or after ptr, scanning with wrap.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            int k;
            k = int'(ptr) + i;
            if (k >= N)
                k = k - N;
            if (en && req[k]) begin
                grant       = '0;
                grant[k]    = 1'b1;
                grant_idx   = IW'(k);
                grant_valid = 1'b1;
            end
        end
        ptr_nxt = ptr;
        if (grant_valid) begin
            if (grant_idx == IW'(N - 1))
                ptr_nxt = '0;
            else
                ptr_nxt = grant_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else
            ptr <= ptr_nxt;
    end

endmodule

// File: rtl/lpf_param_sequencer.sv
// Slews per-channel ladder filter g/resonance toward latched targets.
// One shared slew unit is time-shared by round-robin.
module lpf_param_sequencer
    import lpf_ctrl_pkg::*;
#(
    parameter int                  W       = COEF_W,
    parameter int                  N       = 4,
    parameter logic signed [W-1:0] STEP    = STEP_DEF,
    parameter logic signed [W-1:0] G_MAX   = G_MAX_DEF,
    parameter logic signed [W-1:0] RES_MAX = RES_MAX_DEF,
    parameter logic signed [W-1:0] G_INIT  = G_INIT_DEF
) (
    input  logic           sample_clk,
    input  logic           rst,
    input  logic [N-1:0]   tgt_valid,
    input  logic [N*W-1:0] tgt_g,
    input  logic [N*W-1:0] tgt_res,
    input  logic           snap,
    input  logic           hold,
    output logic [N*W-1:0] g_out,
    output logic [N*W-1:0] res_out,
    output logic [N-1:0]   settled,
    output logic           busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic signed [W-1:0] live_g   [N];
    logic signed [W-1:0] live_res [N];
    logic signed [W-1:0] trg_g    [N];
    logic signed [W-1:0] trg_res  [N];
    logic signed [W-1:0] lat_g    [N];
    logic signed [W-1:0] lat_res  [N];

    logic [N-1:0]        active;
    logic [N-1:0]        grant;
    logic [IW-1:0]       grant_idx;
    logic                grant_valid;
    logic                svc_en;
    logic signed [W-1:0] nxt_g;
    logic signed [W-1:0] nxt_res;

    assign svc_en = ~hold & ~snap;

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_arb (
        .clk         (sample_clk),
        .rst         (rst),
        .en          (svc_en),
        .req         (active),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Clamp incoming targets and flag channels still off target.
    always_comb begin
        for (int c = 0; c < N; c++) begin
            lat_g[c]   = W'(clamp_range(int'($signed(tgt_g[c*W +: W])),
                                        int'(G_MAX)));
            lat_res[c] = W'(clamp_range(int'($signed(tgt_res[c*W +: W])),
                                        int'(RES_MAX)));
            active[c]  = (live_g[c] != trg_g[c]) ||
                         (live_res[c] != trg_res[c]);
            g_out[c*W +: W]   = live_g[c];
            res_out[c*W +: W] = live_res[c];
        end
        settled = ~active;
        busy    = |active;
    end

    // Shared slew unit: one step toward target for the granted channel.
    always_comb begin
        int dg;
        int dr;
        dg = int'(trg_g[grant_idx]) - int'(live_g[grant_idx]);
        dr = int'(trg_res[grant_idx]) - int'(live_res[grant_idx]);
        nxt_g   = W'(int'(live_g[grant_idx]) +
                     step_limit(dg, int'(STEP)));
        nxt_res = W'(int'(live_res[grant_idx]) +
                     step_limit(dr, int'(STEP)));
    end

    // Target registers latch clamped values on their strobe.
    always_ff @(posedge sample_clk) begin
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                trg_g[c]   <= G_INIT;
                trg_res[c] <= '0;
            end else if (tgt_valid[c]) begin
                trg_g[c]   <= lat_g[c];
                trg_res[c] <= lat_res[c];
            end
        end
    end

    // Live values: snap to targets, or take the granted slew step.
    always_ff @(posedge sample_clk) begin
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                live_g[c]   <= G_INIT;
                live_res[c] <= '0;
            end else if (snap) begin
                live_g[c]   <= trg_g[c];
                live_res[c] <= trg_res[c];
            end else if (grant_valid && grant[c]) begin
                live_g[c]   <= nxt_g;
                live_res[c] <= nxt_res;
            end
        end
    end

endmodule
